// File: rtl/cpu7_csr_access_pkg.sv
// Shared encodings for the CSR access initiator: opcode and FSM state types
// plus the default port widths.
package cpu7_csr_access_pkg;

    localparam int GRLEN_DEF   = 32;
    localparam int CSR_BIT_DEF = 14;

    typedef enum logic [1:0] {
        CSR_OP_RD   = 2'b00,
        CSR_OP_WR   = 2'b01,
        CSR_OP_XCHG = 2'b10,
        CSR_OP_RSV  = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        CSRA_IDLE = 2'b00,
        CSRA_RD   = 2'b01,
        CSRA_WR   = 2'b10,
        CSRA_RSP  = 2'b11
    } csra_state_e;

    // True for the ops that update the CSR (csrwr, csrxchg).
    function automatic logic op_writes(input csr_op_e op);
        return (op == CSR_OP_WR) || (op == CSR_OP_XCHG);
    endfunction

endpackage

// File: rtl/cpu7_csr_access.sv
// CSR access initiator: takes one csrrd/csrwr/csrxchg from EX, reads the old
// CSR value, optionally writes the new (merged) value and returns the old
// value to WB. All outputs come from registered state only.
module cpu7_csr_access
    import cpu7_csr_access_pkg::*;
#(
    parameter int GRLEN   = GRLEN_DEF,
    parameter int CSR_BIT = CSR_BIT_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [CSR_BIT-1:0] req_csr,
    input  logic [GRLEN-1:0]   req_wval,
    input  logic [GRLEN-1:0]   req_mask,
    input  logic               flush,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [GRLEN-1:0]   rsp_data,
    output logic               rsp_err,
    output logic [CSR_BIT-1:0] csr_raddr,
    input  logic [GRLEN-1:0]   csr_rdata,
    output logic [CSR_BIT-1:0] csr_waddr,
    output logic [GRLEN-1:0]   csr_wdata,
    output logic               csr_wen
);

    csra_state_e        state_q, state_d;
    csr_op_e            op_q;
    logic [CSR_BIT-1:0] addr_q;
    logic [GRLEN-1:0]   wval_q;
    logic [GRLEN-1:0]   mask_q;
    logic [GRLEN-1:0]   old_q;

    logic accept;
    assign accept = (state_q == CSRA_IDLE) && req_valid && !flush;

    // State register with synchronous reset; reset abandons any operation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!resetn) state_q <= CSRA_IDLE;
        else         state_q <= state_d;
    end

    // Request capture in IDLE and old-value capture in RD.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q   <= CSR_OP_RD;
            addr_q <= '0;
            wval_q <= '0;
            mask_q <= '0;
            old_q  <= '0;
        end else begin
            if (accept) begin
                op_q   <= csr_op_e'(req_op);
                addr_q <= req_csr;
                wval_q <= req_wval;
                mask_q <= req_mask;
            end
            if (state_q == CSRA_RD) old_q <= csr_rdata;
        end
    end

    // Next-state logic; flush is honoured in IDLE, RD and RSP but not in WR,
    // where the write is already committing.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            CSRA_IDLE: if (accept)                 state_d = CSRA_RD;
            CSRA_RD:   state_d = flush ? CSRA_IDLE : CSRA_WR;
            CSRA_WR:   state_d = CSRA_RSP;
            CSRA_RSP:  if (flush || rsp_ready)     state_d = CSRA_IDLE;
            default:   state_d = CSRA_IDLE;
        endcase
    end

    // Address ports simply follow the captured CSR number in every state.
    assign csr_raddr = addr_q;
    assign csr_waddr = addr_q;

    // Moore outputs decoded from the current state and captured operands.
    always_comb begin
        req_ready = 1'b0;
        csr_wen   = 1'b0;
        csr_wdata = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        unique case (state_q)
            CSRA_IDLE: req_ready = 1'b1;
            CSRA_WR: begin
                csr_wen = op_writes(op_q);
                if (op_q == CSR_OP_WR)
                    csr_wdata = wval_q;
                else if (op_q == CSR_OP_XCHG)
                    csr_wdata = (old_q & ~mask_q) | (wval_q & mask_q);
            end
            CSRA_RSP: begin
                rsp_valid = 1'b1;
                rsp_err   = (op_q == CSR_OP_RSV);
                rsp_data  = (op_q == CSR_OP_RSV) ? '0 : old_q;
            end
            default: ;
        endcase
    end

endmodule
